// File: rtl/cu_pkg.sv
// Shared encodings for the risc_control_unit FSM:
// states, instruction classes, branch conditions, ALU pass-through opcodes.
package cu_pkg;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EX_ALU  = 4'd3,
        EX_LD   = 4'd4,
        EX_ST   = 4'd5,
        EX_BR   = 4'd6,
        EX_JR   = 4'd7,
        HALT    = 4'd8,
        ILLEGAL = 4'd9
    } state_t;

    localparam logic [2:0] CLS_ALU   = 3'b000;
    localparam logic [2:0] CLS_LOAD  = 3'b001;
    localparam logic [2:0] CLS_STORE = 3'b010;
    localparam logic [2:0] CLS_BR    = 3'b011;
    localparam logic [2:0] CLS_JR    = 3'b100;
    localparam logic [2:0] CLS_HALT  = 3'b111;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_Z  = 3'b001;
    localparam logic [2:0] COND_NZ = 3'b010;
    localparam logic [2:0] COND_N  = 3'b011;
    localparam logic [2:0] COND_NN = 3'b100;
    localparam logic [2:0] COND_C  = 3'b101;
    localparam logic [2:0] COND_NC = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    localparam logic [3:0] ALU_PASS_R = 4'h0;
    localparam logic [3:0] ALU_PASS_S = 4'h1;

endpackage

// File: rtl/cu_cond_eval.sv
// Branch condition evaluator over the latched C/N/Z flags.
// Purely combinational.
module cu_cond_eval
    import cu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       c,
    input  logic       n,
    input  logic       z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = z;
            COND_NZ: taken = !z;
            COND_N:  taken = n;
            COND_NN: taken = !n;
            COND_C:  taken = c;
            COND_NC: taken = !c;
            COND_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch, decode,
// one execute state per instruction class, plus the latched status flags.
module risc_control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    input  logic        mem_rdy,
    output logic        adr_sel,
    output logic        s_sel,
    output logic        pc_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        W_en,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  ALU_OP,
    output logic        mr_en,
    output logic        mw_en,
    output logic        halt,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t st;
    logic   c_q, n_q, z_q;
    logic   taken;

    cu_cond_eval u_cond (
        .cond  (IR[12:10]),
        .c     (c_q),
        .n     (n_q),
        .z     (z_q),
        .taken (taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= RESET_S;
            c_q <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            if (st == EX_ALU) begin
                c_q <= C;
                n_q <= N;
                z_q <= Z;
            end
            unique case (st)
                RESET_S: st <= FETCH;
                FETCH:   if (mem_rdy) st <= DECODE;
                DECODE: begin
                    unique case (IR[15:13])
                        CLS_ALU:   st <= EX_ALU;
                        CLS_LOAD:  st <= EX_LD;
                        CLS_STORE: st <= EX_ST;
                        CLS_BR:    st <= EX_BR;
                        CLS_JR:    st <= EX_JR;
                        CLS_HALT:  st <= HALT;
                        default:   st <= ILLEGAL;
                    endcase
                end
                EX_LD, EX_ST: if (mem_rdy) st <= FETCH;
                EX_ALU, EX_BR, EX_JR: st <= FETCH;
                HALT:    st <= HALT;
                ILLEGAL: st <= ILLEGAL;
                default: st <= ILLEGAL;
            endcase
        end
    end

    // Register addresses are only meaningful once IR holds the new word.
    logic addr_on;
    assign addr_on = (st == DECODE) || (st == EX_ALU) || (st == EX_LD)
                  || (st == EX_ST) || (st == EX_BR) || (st == EX_JR);

    assign W_Adr = addr_on ? IR[8:6] : 3'd0;
    assign R_Adr = addr_on ? IR[5:3] : 3'd0;
    assign S_Adr = addr_on ? IR[2:0] : 3'd0;
    assign state = st;

    always_comb begin
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_sel  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        W_en    = 1'b0;
        ALU_OP  = 4'h0;
        mr_en   = 1'b0;
        mw_en   = 1'b0;
        halt    = 1'b0;
        illegal = 1'b0;
        unique case (st)
            FETCH: begin
                mr_en  = 1'b1;
                ir_ld  = mem_rdy;
                pc_inc = mem_rdy;
            end
            EX_ALU: begin
                W_en   = 1'b1;
                ALU_OP = IR[12:9];
            end
            EX_LD: begin
                adr_sel = 1'b1;
                mr_en   = 1'b1;
                s_sel   = 1'b1;
                ALU_OP  = ALU_PASS_S;
                W_en    = mem_rdy;
            end
            EX_ST: begin
                adr_sel = 1'b1;
                mw_en   = 1'b1;
                ALU_OP  = ALU_PASS_S;
            end
            EX_BR: pc_ld = taken;
            EX_JR: begin
                ALU_OP = ALU_PASS_R;
                pc_sel = 1'b1;
                pc_ld  = 1'b1;
            end
            HALT:    halt    = 1'b1;
            ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// Randomized bench for risc_control_unit: an instruction-level model
// predicts every output in every cycle, plus directed scenarios.
module tb_risc_control_unit;

    typedef struct packed {
        logic       adr_sel;
        logic       s_sel;
        logic       pc_sel;
        logic       pc_ld;
        logic       pc_inc;
        logic       ir_ld;
        logic       w_en;
        logic [2:0] w_adr;
        logic [2:0] r_adr;
        logic [2:0] s_adr;
        logic [3:0] alu_op;
        logic       mr_en;
        logic       mw_en;
        logic       halt;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        C = 1'b0, N = 1'b0, Z = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  ALU_OP;
    logic        mr_en, mw_en, halt, illegal;
    logic [3:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    logic fc = 1'b0, fn = 1'b0, fz = 1'b0;

    outs_t obs;
    assign obs = {adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en,
                  W_Adr, R_Adr, S_Adr, ALU_OP, mr_en, mw_en,
                  halt, illegal, state};

    risc_control_unit dut (
        .clk     (clk),
        .reset   (reset),
        .IR      (IR),
        .C       (C),
        .N       (N),
        .Z       (Z),
        .mem_rdy (mem_rdy),
        .adr_sel (adr_sel),
        .s_sel   (s_sel),
        .pc_sel  (pc_sel),
        .pc_ld   (pc_ld),
        .pc_inc  (pc_inc),
        .ir_ld   (ir_ld),
        .W_en    (W_en),
        .W_Adr   (W_Adr),
        .R_Adr   (R_Adr),
        .S_Adr   (S_Adr),
        .ALU_OP  (ALU_OP),
        .mr_en   (mr_en),
        .mw_en   (mw_en),
        .halt    (halt),
        .illegal (illegal),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic br_taken(input logic [2:0] cond);
        case (cond)
            3'd0: return 1'b1;
            3'd1: return fz;
            3'd2: return !fz;
            3'd3: return fn;
            3'd4: return !fn;
            3'd5: return fc;
            3'd6: return !fc;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic rdy);
        mem_rdy = rdy;
        {C, N, Z} = 3'($urandom);
    endtask

    task automatic cyc(input string tag, input outs_t e);
        @(negedge clk);
        check(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0);
        @(negedge clk);
        check("rst_hold", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        fc = 1'b0; fn = 1'b0; fz = 1'b0;
        cyc("rst_s", '0);
    endtask

    task automatic run_instr(input logic [15:0] ir, input int wf,
                             input int wm, input logic [2:0] cnz,
                             input bit abort);
        outs_t e, a;
        logic [2:0] cls;
        cls = ir[15:13];
        for (int i = 0; i < wf; i++) begin
            drive(1'b0);
            e = '0; e.mr_en = 1'b1; e.state = 4'd1;
            cyc("fetch_wait", e);
        end
        drive(1'b1);
        e = '0; e.mr_en = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        e.state = 4'd1;
        cyc("fetch", e);
        IR = ir;
        a = '0; a.w_adr = ir[8:6]; a.r_adr = ir[5:3]; a.s_adr = ir[2:0];
        drive(1'($urandom));
        e = a; e.state = 4'd2;
        cyc("decode", e);
        case (cls)
            3'b000: begin
                drive(1'($urandom));
                {C, N, Z} = cnz;
                e = a; e.w_en = 1'b1; e.alu_op = ir[12:9]; e.state = 4'd3;
                cyc("ex_alu", e);
                {fc, fn, fz} = cnz;
            end
            3'b001, 3'b010: begin
                e = a; e.adr_sel = 1'b1; e.alu_op = 4'h1;
                if (cls == 3'b001) begin
                    e.mr_en = 1'b1; e.s_sel = 1'b1; e.state = 4'd4;
                end else begin
                    e.mw_en = 1'b1; e.state = 4'd5;
                end
                for (int i = 0; i < wm; i++) begin
                    drive(1'b0);
                    cyc("ex_mem_wait", e);
                end
                if (abort) begin
                    drive(1'b0);
                    @(negedge clk);
                    check("st_before_abort", 32'(obs), 32'(e));
                    reset = 1'b0;
                    #1;
                    check("st_abort", 32'(obs), 32'h0);
                    @(posedge clk);
                    #1;
                    reset = 1'b1;
                    fc = 1'b0; fn = 1'b0; fz = 1'b0;
                    cyc("rst_s_after_abort", '0);
                    return;
                end
                drive(1'b1);
                if (cls == 3'b001) e.w_en = 1'b1;
                cyc("ex_mem_done", e);
            end
            3'b011: begin
                drive(1'($urandom));
                e = a; e.pc_ld = br_taken(ir[12:10]); e.state = 4'd6;
                cyc("ex_br", e);
            end
            3'b100: begin
                drive(1'($urandom));
                e = a; e.pc_sel = 1'b1; e.pc_ld = 1'b1; e.alu_op = 4'h0;
                e.state = 4'd7;
                cyc("ex_jr", e);
            end
            3'b111: begin
                for (int i = 0; i < 3; i++) begin
                    drive(1'($urandom));
                    e = '0; e.halt = 1'b1; e.state = 4'd8;
                    cyc("halt", e);
                end
            end
            default: begin
                for (int i = 0; i < 3; i++) begin
                    drive(1'($urandom));
                    e = '0; e.illegal = 1'b1; e.state = 4'd9;
                    cyc("illegal", e);
                end
            end
        endcase
    endtask

    initial begin
        logic [15:0] r;
        drive(1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(16'h0853, 0, 0, 3'b001, 1'b0);
        run_instr(16'h64FC, 0, 0, 3'b000, 1'b0);
        run_instr(16'h0853, 0, 0, 3'b000, 1'b0);
        run_instr(16'h64FC, 0, 0, 3'b000, 1'b0);
        run_instr(16'h2150, 0, 2, 3'b000, 1'b0);
        run_instr(16'h0853, 3, 0, 3'b111, 1'b0);
        run_instr(16'h8018, 1, 0, 3'b000, 1'b0);
        run_instr(16'hE000, 0, 0, 3'b000, 1'b0);
        do_reset();
        run_instr(16'hA000, 0, 0, 3'b000, 1'b0);
        do_reset();
        run_instr(16'hC000, 0, 0, 3'b000, 1'b0);
        do_reset();
        run_instr(16'h4053, 0, 1, 3'b000, 1'b1);
        run_instr(16'h0853, 0, 0, 3'b010, 1'b0);

        for (int k = 0; k < 400; k++) begin
            r = 16'($urandom);
            if (r[15:13] >= 3'b101 && $urandom_range(0, 7) != 0)
                r[15] = 1'b0;
            run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3),
                      3'($urandom), ($urandom_range(0, 31) == 0));
            if (r[15:13] >= 3'b101) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
